// File: rtl/trng_pkg.sv
// Shared encodings for the TRNG seed fetch path: FSM state codes and error codes.
package trng_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_POP   = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RCT     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/trng_rct.sv
// Online repetition-count health test: trips when RCT_LIMIT identical words arrive in a row.
// Held word and count persist across seeds; only reset or clear restarts the test.
module trng_rct #(
    parameter int Dbw       = 32,
    parameter int RCT_LIMIT = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           en,
    input  logic [Dbw-1:0] word,
    output logic           fail
);

    localparam int CW = $clog2(RCT_LIMIT + 1);

    logic [Dbw-1:0] held_q;
    logic [CW-1:0]  cnt_q, cnt_d;

    // A zero count means nothing has been held yet, so the first word always starts a new run.
    always_comb begin
        cnt_d = CW'(1);
        if (cnt_q != '0 && word == held_q)
            cnt_d = cnt_q + CW'(1);
    end

    assign fail = en && (cnt_d == CW'(RCT_LIMIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            held_q <= '0;
            cnt_q  <= '0;
        end else if (en) begin
            held_q <= word;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/trng_seed_fetch.sv
// Pops SEED_WORDS words from the TRNG memory on a start pulse, health-tests each word,
// and presents the packed seed with valid/ack; stalls or RCT failures end in a sticky error.
module trng_seed_fetch #(
    parameter int Dbw        = 32,
    parameter int SEED_WORDS = 8,
    parameter int RCT_LIMIT  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      seed_valid,
    input  logic                      seed_ack,
    output logic [SEED_WORDS*Dbw-1:0] seed_out,
    output logic                      trng_ren,
    output logic                      trng_read,
    input  logic                      trng_valid,
    input  logic [Dbw-1:0]            trng_out,
    output logic                      health_err,
    output logic [1:0]                err_code,
    input  logic                      clear_err
);

    import trng_pkg::*;

    localparam int IW = $clog2(SEED_WORDS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SEED_WORDS - 1);
    localparam logic [TW-1:0] TMO_HIT  = TW'(TIMEOUT);

    logic [2:0]                state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [1:0]                err_q, err_d;
    logic [SEED_WORDS*Dbw-1:0] seed_q, seed_d;
    logic                      rct_fail;
    logic                      rct_clear;

    assign rct_clear = (state_q == ST_ERROR) && clear_err;

    trng_rct #(
        .Dbw       (Dbw),
        .RCT_LIMIT (RCT_LIMIT)
    ) u_rct (
        .clock (clock),
        .reset (reset),
        .clear (rct_clear),
        .en    (state_q == ST_POP),
        .word  (trng_out),
        .fail  (rct_fail)
    );

    // The timeout counter falls back to zero in every non-WAIT state, so each WAIT entry starts fresh.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        err_d   = err_q;
        seed_d  = seed_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_ARM;
                idx_d   = '0;
                seed_d  = '0;
            end
            ST_ARM:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (trng_valid) begin
                    state_d = ST_POP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TMO_HIT) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            ST_POP: begin
                seed_d[idx_q*Dbw +: Dbw] = trng_out;
                if (rct_fail) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_RCT;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_WAIT;
            ST_DONE: if (seed_ack) state_d = ST_IDLE;
            ST_ERROR: if (clear_err) begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= ERR_NONE;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            seed_q  <= seed_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign seed_valid = (state_q == ST_DONE);
    assign trng_ren   = (state_q == ST_ARM) || (state_q == ST_WAIT) ||
                        (state_q == ST_POP) || (state_q == ST_GAP);
    assign trng_read  = (state_q == ST_POP);
    assign health_err = (state_q == ST_ERROR);
    assign err_code   = err_q;
    assign seed_out   = seed_q;

endmodule

// File: tb/tb_trng_seed_fetch.sv
// Randomized self-checking bench for trng_seed_fetch against a queue-based TRNG memory
// and a word-stream health/seed model.
module tb_trng_seed_fetch;

    localparam int DBW   = 32;
    localparam int SW    = 8;
    localparam int RL    = 4;
    localparam int TMO   = 16;
    localparam int SEEDW = SW * DBW;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             seed_ack = 1'b0;
    logic             clear_err = 1'b0;
    logic             trng_valid = 1'b0;
    logic [DBW-1:0]   trng_out = '0;
    logic             busy, seed_valid, trng_ren, trng_read, health_err;
    logic [1:0]       err_code;
    logic [SEEDW-1:0] seed_out;

    trng_seed_fetch #(
        .Dbw        (DBW),
        .SEED_WORDS (SW),
        .RCT_LIMIT  (RL),
        .TIMEOUT    (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .seed_valid (seed_valid),
        .seed_ack   (seed_ack),
        .seed_out   (seed_out),
        .trng_ren   (trng_ren),
        .trng_read  (trng_read),
        .trng_valid (trng_valid),
        .trng_out   (trng_out),
        .health_err (health_err),
        .err_code   (err_code),
        .clear_err  (clear_err)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [SEEDW-1:0] got, input logic [SEEDW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TRNG memory model and stream bookkeeping
    logic [DBW-1:0] mem[$];
    logic [DBW-1:0] pre[SW];
    int  vmode = 0;
    int  stop_after = 3;
    int  seed_pops = 0;
    int  strobes = 0;
    int  consec = 0;
    int  cyc = 0;
    int  lowrun = 0;
    bit  pend_pop = 0;
    bit  prev_rd = 0;
    logic [DBW-1:0] held_m = '0;
    int  cnt_m = 0;

    // One clock: pop the word taken at the last edge, observe strobes, then drive the memory.
    task automatic step();
        bit g;
        @(negedge clock);
        if (pend_pop && mem.size() > 0) begin
            mem.delete(0);
            seed_pops++;
        end
        cyc++;
        if (trng_read) begin
            strobes++;
            if (prev_rd) consec++;
        end
        prev_rd  = trng_read;
        pend_pop = trng_read;
        case (vmode)
            0:       g = 1'b1;
            1:       g = (cyc % 2) == 0;
            2:       g = ($urandom_range(3) != 0) || (lowrun >= 6);
            default: g = (seed_pops < stop_after);
        endcase
        lowrun     = g ? 0 : lowrun + 1;
        trng_valid = g && (mem.size() > 0);
        trng_out   = (mem.size() > 0) ? mem[0] : '0;
    endtask

    task automatic run_seed(input string tag, input int mode, input int hold);
        int lim, k_err, t0, n, rel;
        logic [SEEDW-1:0] exp_seed;
        bit stable;
        lim      = (mode == 3) ? stop_after : SW;
        k_err    = -1;
        exp_seed = '0;
        for (int k = 0; k < lim && k_err < 0; k++) begin
            if (cnt_m > 0 && pre[k] == held_m) cnt_m++;
            else cnt_m = 1;
            held_m = pre[k];
            if (cnt_m == RL) k_err = k;
        end
        for (int k = 0; k < SW; k++) exp_seed[k*DBW +: DBW] = pre[k];

        mem.delete();
        for (int k = 0; k < SW; k++) mem.push_back(pre[k]);
        vmode = mode; seed_pops = 0; strobes = 0; consec = 0; lowrun = 0;

        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        check({tag, "_arm_seed_clr"}, seed_out, '0);
        n = 0;
        while (!seed_valid && !health_err && n < 400) begin
            step();
            n++;
        end
        rel = cyc - t0 + 1;

        if (k_err >= 0 || mode == 3) begin
            check({tag, "_health_err"}, health_err, 1);
            check({tag, "_err_code"}, err_code, (k_err >= 0) ? 2'b01 : 2'b10);
            check({tag, "_ren_in_err"}, trng_ren, 0);
            check({tag, "_no_seed_valid"}, seed_valid, 0);
            if (k_err >= 0) check({tag, "_rct_strobes"}, strobes, k_err + 1);
            if (mode == 0) check({tag, "_rct_cycle"}, rel, 4 + 3 * k_err);
            if (mode == 3 && k_err < 0) check({tag, "_tmo_cycle"}, rel, 3 + 3 * (stop_after - 1) + 2 + TMO);
            clear_err = 1'b1;
            step();
            clear_err = 1'b0;
            check({tag, "_clr_busy"}, busy, 0);
            check({tag, "_clr_herr"}, health_err, 0);
            check({tag, "_clr_code"}, err_code, 2'b00);
            cnt_m = 0;
        end else begin
            check({tag, "_seed_valid"}, seed_valid, 1);
            check({tag, "_seed"}, seed_out, exp_seed);
            check({tag, "_strobes"}, strobes, SW);
            check({tag, "_no_double_pop"}, consec, 0);
            check({tag, "_mem_drained"}, mem.size(), 0);
            if (mode == 0) check({tag, "_valid_cycle"}, rel, 3 * SW + 1);
            stable = 1'b1;
            repeat (hold) begin
                step();
                if (seed_out !== exp_seed || seed_valid !== 1'b1) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, stable, 1);
            seed_ack = 1'b1;
            start    = 1'b1;
            step();
            seed_ack = 1'b0;
            start    = 1'b0;
            check({tag, "_ack_idle"}, busy, 0);
            check({tag, "_ack_valid_low"}, seed_valid, 0);
            step();
            check({tag, "_start_ignored"}, busy, 0);
            check({tag, "_seed_kept"}, seed_out, exp_seed);
        end
    endtask

    initial begin
        int n;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_valid", seed_valid, 0);
        check("rst_ren", trng_ren, 0);
        check("rst_read", trng_read, 0);
        check("rst_herr", health_err, 0);
        check("rst_code", err_code, 2'b00);
        check("rst_seed", seed_out, '0);
        reset = 1'b0;
        step();

        for (int k = 0; k < SW; k++) pre[k] = DBW'(k + 1);
        run_seed("seq", 0, 50);

        for (int k = 0; k < SW; k++) pre[k] = (k < 4) ? 32'hDEADBEEF : DBW'(32'h100 + k);
        run_seed("rct", 0, 0);

        stop_after = 3;
        for (int k = 0; k < SW; k++) pre[k] = DBW'(32'h21 + k);
        run_seed("tmo", 3, 0);

        for (int k = 0; k < SW; k++) pre[k] = DBW'(32'h31 + k);
        run_seed("toggle", 1, 3);

        // Abort a fetch with reset while the fifth pop strobe is showing.
        mem.delete();
        for (int k = 0; k < SW; k++) mem.push_back(DBW'(k + 1));
        vmode = 0; strobes = 0; seed_pops = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(trng_read && strobes == 5) && n < 100) begin
            step();
            n++;
        end
        check("pre_rst_5th_pop", trng_read, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_read", trng_read, 0);
        check("mid_rst_ren", trng_ren, 0);
        check("mid_rst_seed", seed_out, '0);
        pend_pop = 1'b0;
        prev_rd  = 1'b0;
        step();
        reset = 1'b0;
        cnt_m = 0;
        check("mid_rst_no_pop", seed_pops, 4);
        for (int k = 0; k < SW; k++) pre[k] = DBW'(32'h41 + k);
        run_seed("post_rst", 0, 2);

        for (int s = 0; s < 12; s++) begin
            for (int k = 0; k < SW; k++)
                pre[k] = (k > 0 && $urandom_range(2) == 0) ? pre[k-1] : DBW'($urandom);
            run_seed($sformatf("rnd%0d", s), int'($urandom_range(2)), int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_seed_fetch.md
# trng_seed_fetch

Downstream consumer of the TRNG top (round-robin TRNG units feeding the circular TRNG memory). On a single start pulse it drives the memory read handshake, pops `SEED_WORDS` consecutive `Dbw`-bit words, and runs an online repetition-count health test on every word. It then presents one packed seed with a valid/ack handshake to the PQC cores that need seeds. A stalled source or a failed health test yields a sticky error instead of a seed.

## Interface
Parameters:
- `Dbw`, 32, TRNG word width; equal to the TRNG memory output width.
- `SEED_WORDS`, 8, words per seed, ≥2 (default seed = 256 bits).
- `RCT_LIMIT`, 4, number of consecutive identical words that trips the health test, ≥2.
- `TIMEOUT`, 1024, maximum cycles spent in WAIT before a timeout error.

Ports:
- `clock`  in  1  system/AXI clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle request for a new seed; accepted only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `seed_valid`  out  1  seed available; high in DONE only.
- `seed_ack`  in  1  consumer has taken the seed; acted on only while `seed_valid`=1.
- `seed_out`  out  `SEED_WORDS*Dbw`  packed seed; word k occupies bits [k*Dbw +: Dbw].
- `trng_ren`  out  1  TRNG memory read enable; high in ARM, WAIT, POP and GAP.
- `trng_read`  out  1  one-cycle pop strobe; high in POP only.
- `trng_valid`  in  1  TRNG memory holds an unread word.
- `trng_out`  in  `Dbw`  current head word of the TRNG memory.
- `health_err`  out  1  sticky error flag; high in ERROR.
- `err_code`  out  2  01 = repetition-count failure, 10 = timeout; 00 otherwise.
- `clear_err`  in  1  one-cycle pulse; leaves ERROR.

## Operation
- FSM states: IDLE, ARM, WAIT, POP, GAP, DONE, ERROR.
- IDLE: on `start` go to ARM, clear the word index, clear the seed register.
- ARM: one cycle with `trng_ren`=1 so the memory output settles; then go to WAIT.
- WAIT:
  - `trng_valid`=1: go to POP.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT`, go to ERROR with code 10.
  - The timeout counter clears on every entry to WAIT.
- POP:
  - `trng_read`=1. Capture `trng_out` into seed word [index]. Feed the word to the RCT.
  - If the RCT trips: go to ERROR with code 01.
  - Else if index = `SEED_WORDS`-1: go to DONE.
  - Else: index+1, go to GAP.
- GAP: one cycle; `trng_valid` is ignored because it lags the pop. Then go to WAIT.
- DONE:
  - `seed_valid`=1; `seed_out` is stable.
  - On `seed_ack`: go to IDLE. `seed_out` holds its value until the next `start`.
- ERROR:
  - `health_err`=1, `trng_ren`=0; the partial seed is never exposed (`seed_valid`=0).
  - On `clear_err`: go to IDLE and clear the RCT count and `err_code`.
- RCT:
  - Holds the last captured word and a repeat count. Count = 1 on a new value; +1 when the word equals the held word.
  - Trips when count = `RCT_LIMIT`.
  - The held word and count persist across seeds (continuous test) and clear only on reset or `clear_err`.
- Counter widths: index is clog2(`SEED_WORDS`); the timeout counter is clog2(`TIMEOUT`+1); both saturate-free by construction.

## Timing
- Reset values:
  - Outputs: `busy`, `seed_valid`, `trng_ren`, `trng_read`, `health_err` = 0; `err_code` = 00; `seed_out` = 0.
  - State: IDLE.
- Reset mid-operation: all outputs fall immediately (asynchronous). No pop is issued after reset, and the partial seed is lost.
- With `trng_valid` held at 1 and `start` sampled at edge 0:
  - ARM in cycle 1.
  - POP of word k in cycle 3+3k.
  - `seed_valid` rises in cycle 3·`SEED_WORDS`+1, i.e. cycle 25 for the defaults.
- `trng_read` is never high for two consecutive cycles. Exactly `SEED_WORDS` strobes occur per successful seed.
- Ignored inputs:
  - `start` outside IDLE, including in the same cycle as `seed_ack` in DONE; the consumer must reissue it.
  - `seed_ack` outside DONE.
  - `clear_err` outside ERROR.
- `trng_valid` dropping during GAP or WAIT only stalls the fetch; the timeout counter restarts on each WAIT entry.

## Structure
- Shared package `trng_pkg`: the FSM state encoding (3 bits) and the `err_code` constants `ERR_NONE`, `ERR_RCT`, `ERR_TIMEOUT`.
- Sub-module `trng_rct`: repetition-count test with held word and counter; inputs `clock`, `reset`, `clear`, `en`, `word`; output `fail`.
- Top level: FSM, index and timeout counters, seed register.

## Test plan
- Memory model preloaded with words 0x1,0x2,…,0x8, `trng_valid` always 1, `start` pulse → `seed_out` = {0x8,…,0x1} with word 0 in bits [31:0]; `seed_valid` rises at cycle 25; exactly 8 `trng_read` strobes.
- Hold `seed_ack`=0 for 50 cycles, then pulse it with `start` asserted in the same cycle → `seed_out` stays stable while `seed_valid`=1; the FSM returns to IDLE and the concurrent `start` is ignored.
- Source supplies 0xDEADBEEF four times in a row → ERROR on the 4th POP, `err_code`=01, `seed_valid` never asserted; `clear_err` → IDLE with `busy`=0.
- `trng_valid`=0 forever after the 3rd word, `TIMEOUT`=16 → ERROR with `err_code`=10 after 16 WAIT cycles; `trng_ren`=0 in ERROR.
- `trng_valid` toggling 1/0 every other cycle → complete seed with correct word order and no double pops.
- Assert `reset` during the 5th POP → all outputs 0 in the same cycle; a following `start` produces a fresh 8-word seed.
